// File: rtl/fifo_pkg.sv
// Shared FIFO constants and the skid-buffer fill-level encoding.
// Used by the FIFO read-side stream stage and its sub-blocks.
package fifo_pkg;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;
endpackage

// File: rtl/fifo_rd_stream_if.sv
// Valid/ready output stream of the FIFO drain stage.
// The master drives valid and data; the slave drives ready.
interface fifo_rd_stream_if #(
  parameter int WIDTH = fifo_pkg::WIDTH
);
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ready;

  modport master (
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    output m_ready
  );
endinterface

// File: rtl/fifo_rd_stream_skid_buf2.sv
// Two-entry circular skid buffer with 1-bit head/tail pointers.
// Fill level is a small state machine: EMPTY, ONE, FULL.
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int WIDTH = fifo_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       occ
);

  occ_e             state_q;
  occ_e             state_d;
  logic [WIDTH-1:0] mem [2];
  logic             head;
  logic             tail;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OCC_EMPTY;
      head    <= 1'b0;
      tail    <= 1'b0;
      mem[0]  <= '0;
      mem[1]  <= '0;
    end else if (clear) begin
      state_q <= OCC_EMPTY;
      head    <= 1'b0;
      tail    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) begin
        mem[tail] <= din;
        tail      <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OCC_EMPTY: begin
        if (push) state_d = OCC_ONE;
      end
      OCC_ONE: begin
        if (push && !pop)      state_d = OCC_FULL;
        else if (!push && pop) state_d = OCC_EMPTY;
      end
      OCC_FULL: begin
        if (pop && !push) state_d = OCC_ONE;
      end
      default: state_d = OCC_EMPTY;
    endcase
  end

  // The issue rule upstream must keep these from ever happening.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && state_q == OCC_FULL));
      assert (!(pop && state_q == OCC_EMPTY));
    end
  end

  assign dout = mem[head];
  assign occ  = state_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO drain stage: turns the registered FIFO read port into a
// valid/ready stream through a 2-entry skid buffer.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int WIDTH = fifo_pkg::WIDTH,
  parameter int CNT_W = fifo_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               fifo_empty,
  input  logic [WIDTH-1:0]   fifo_data,
  output logic               fifo_rd_en,
  fifo_rd_stream_if.master   m,
  output logic [CNT_W-1:0]   beat_count,
  output logic [1:0]         occupancy
);

  logic       pend;
  logic       pop;
  logic       push;
  logic [2:0] fill;

  assign pop  = m.m_valid && m.m_ready;
  assign push = pend;

  // Words held plus in flight, net of this cycle's pop.
  assign fill = {1'b0, occupancy} + {2'b00, pend} - {2'b00, pop};

  assign fifo_rd_en = !rst && !clear && !fifo_empty && (fill < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend       <= 1'b0;
      beat_count <= '0;
    end else begin
      pend <= fifo_rd_en;
      if (pop) begin
        beat_count <= beat_count + 1'b1;
      end
    end
  end

  skid_buf2 #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .din   (fifo_data),
    .dout  (m.m_data),
    .occ   (occupancy)
  );

  assign m.m_valid = (occupancy != 2'd0);

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: FIFO model plus in-order stream scoreboard.
// Narrow beat counter so wrap-around is reached quickly.
module tb_fifo_rd_stream;
  import fifo_pkg::*;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          fifo_empty;
  logic [7:0]    fifo_data = 8'h00;
  logic          fifo_rd_en;
  logic [CW-1:0] beat_count;
  logic [1:0]    occupancy;

  fifo_rd_stream_if #(.WIDTH(8)) sif();

  always #5 clk = ~clk;

  fifo_rd_stream #(
    .WIDTH (8),
    .CNT_W (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .m          (sif.master),
    .beat_count (beat_count),
    .occupancy  (occupancy)
  );

  // FIFO with one-cycle registered read
  logic [7:0] mem [0:4095];
  int rp = 0;
  int wp = 0;

  assign fifo_empty = (rp == wp);

  always @(posedge clk) begin
    if (rst || clear) begin
      rp <= wp;
    end else if (fifo_rd_en) begin
      fifo_data <= mem[rp];
      rp        <= rp + 1;
    end
  end

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  logic [7:0] exp_q[$];
  int         cnt = 0;
  bit         acc;
  bit         stall_q = 1'b0;
  logic [7:0] stall_d;

  task automatic load(input int n, input bit seq);
    logic [7:0] w;
    for (int i = 0; i < n; i++) begin
      w = seq ? 8'(i + 1) : 8'($urandom);
      mem[wp] = w;
      wp++;
      exp_q.push_back(w);
    end
  endtask

  task automatic do_reset(input int n, input bit seq);
    rst = 1'b1;
    clear = 1'b0;
    sif.m_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_valid", sif.m_valid, 0);
    chk("rst_data", sif.m_data, 0);
    chk("rst_count", beat_count, 0);
    chk("rst_occ", occupancy, 0);
    exp_q.delete();
    cnt = 0;
    stall_q = 1'b0;
    load(n, seq);
    rst = 1'b0;
    #1;
  endtask

  task automatic step(input bit rdy, input bit clr, input bit wr);
    @(negedge clk);
    chk("beat_count", beat_count, cnt % (1 << CW));
    chk("valid_vs_occ", sif.m_valid, occupancy != 2'd0);
    chk("occ_le2", occupancy <= 2'd2, 1);
    if (stall_q && sif.m_valid) chk("hold", sif.m_data, stall_d);
    if (wr && !clr) load(1, 1'b0);
    sif.m_ready = rdy;
    clear = clr;
    #1;
    if (clr) chk("rd_en_clear", fifo_rd_en, 0);
    acc = sif.m_valid && rdy;
    if (acc) begin
      chk("beat_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("data", sif.m_data, exp_q.pop_front());
      cnt++;
    end
    stall_q = sif.m_valid && !rdy;
    stall_d = sif.m_data;
    if (clr) exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    int bi;
    int p;
    sif.m_ready = 1'b0;

    // streaming with wrap of the 4-bit counter
    do_reset(17, 1'b1);
    chk("rd_en_first", fifo_rd_en, 1);
    bi = 0;
    for (int s = 1; s <= 20; s++) begin
      step(1'b1, 1'b0, 1'b0);
      if (acc) begin
        bi++;
        chk("stream_slot", s, bi + 1);
      end
      if (s == 18) chk("wrap16", beat_count, 0);
      if (s == 19) chk("wrap17", beat_count, 1);
    end
    chk("stream_drained", exp_q.size(), 0);

    // back-pressure
    do_reset(8, 1'b1);
    repeat (6) step(1'b0, 1'b0, 1'b0);
    chk("bp_occ", occupancy, 2);
    chk("bp_rd_en", fifo_rd_en, 0);
    chk("bp_head", sif.m_data, 8'h01);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++)
      step(1'b1, 1'b0, 1'b0);
    chk("bp_drained", exp_q.size(), 0);
    step(1'b0, 1'b0, 1'b0);
    chk("bp_count", beat_count, 8);
    chk("bp_idle", sif.m_valid, 0);

    // alternating ready
    do_reset(10, 1'b1);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++)
      step(i % 2 == 0, 1'b0, 1'b0);
    chk("alt_drained", exp_q.size(), 0);
    step(1'b0, 1'b0, 1'b0);
    chk("alt_count", beat_count, 10);

    // clear with one word held and one in flight
    do_reset(3, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("clr_pre_occ", occupancy, 1);
    step(1'b1, 1'b0, 1'b0);
    chk("clr_valid", sif.m_valid, 0);
    chk("clr_occ", occupancy, 0);
    chk("clr_count", beat_count, 0);
    repeat (5) step(1'b1, 1'b0, 1'b0);

    // randomized traffic with writes and clears
    repeat (6) begin
      do_reset($urandom_range(0, 20), 1'b0);
      p = $urandom_range(1, 4);
      for (int i = 0; i < 80; i++)
        step($urandom_range(0, 3) < p, $urandom_range(0, 29) == 0,
             $urandom_range(0, 2) == 0);
      for (int i = 0; i < 40 && exp_q.size() != 0; i++)
        step(1'b1, 1'b0, 1'b0);
      chk("rand_drained", exp_q.size(), 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
